// File: rtl/data_cache_responder_pkg.sv
// Shared definitions for the data-cache responder.
// Holds the FSM state encoding and the bit positions used to slice a byte
// address into word offset, line index and tag.
package data_cache_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  // Index starts just above the byte offset; the tag is the top of the address.
  localparam int IDX_LSB = 2;
  localparam int TAG_MSB = ADDR_W - 1;

endpackage

// File: rtl/data_cache_responder_line_array.sv
// cache_line_array: LINES x (valid, tag, data) storage for the direct-mapped
// cache.
// Ports:
//   realClock, reset        clock, asynchronous active-high reset (valid only)
//   rd_idx                  asynchronous read index
//   rd_valid/rd_tag/rd_data line contents at rd_idx
//   wr_en/wr_idx            synchronous write strobe and index
//   wr_tag/wr_data          tag and data written; the line becomes valid
module cache_line_array
  import data_cache_responder_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic              realClock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge realClock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data are never reset; a cleared valid bit makes them don't-care.
  always_ff @(posedge realClock) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/data_cache_responder.sv
// data_cache_responder: responder end of the pipeline data-memory interface.
// Direct-mapped, one word per line, write-through, no-write-allocate cache in
// front of a slow req/ack backing memory. outStall gates the pipeline clock.
// Ports:
//   realClock, reset              free-running clock, async active-high reset
//   addressData, value            byte address and store data from MEM stage
//   write, readData               store / load requests (levels)
//   outData, outStall             load data on a hit, pipeline freeze
//   mem_req/we/addr/wdata         registered backing-memory request
//   mem_rdata, mem_ack            backing-memory response
//   hit_count/miss_count/stall_count  wrapping statistics counters
//
// state   | meaning
// IDLE    | lookup; hits answered combinationally, misses/stores launch a request
// RD_MISS | waiting for read ack; fill the line on ack
// WR_THRU | waiting for write ack; update the line only if it hits
// DONE    | one unstalled cycle so the pipeline retires the store
module data_cache_responder
  import data_cache_responder_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic              realClock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addressData,
  input  logic [DATA_W-1:0] value,
  input  logic              write,
  input  logic              readData,
  output logic [DATA_W-1:0] outData,
  output logic              outStall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       stall_count
);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [31:0]       hit_count_q, hit_count_d;
  logic [31:0]       miss_count_q, miss_count_d;
  logic [31:0]       stall_count_q, stall_count_d;
  logic              retry_q, retry_d;

  logic [IDX_W-1:0]  rd_idx;
  logic [TAG_W-1:0]  lookup_tag;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              hit;
  logic              ack;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [TAG_W-1:0]  wr_tag;
  logic [DATA_W-1:0] wr_data;

  logic              out_stall;
  logic [DATA_W-1:0] out_data;

  // Byte offset is never used by a word-wide cache.
  logic unused_byte_offset;
  assign unused_byte_offset = ^addressData[IDX_LSB-1:0];

  // In IDLE the lookup follows the live request; while waiting on memory it
  // follows the latched address so the write-through tag check uses the
  // address actually sent.
  always_comb begin
    if (state_q == IDLE) begin
      rd_idx     = addressData[IDX_LSB +: IDX_W];
      lookup_tag = addressData[TAG_MSB -: TAG_W];
    end else begin
      rd_idx     = mem_addr_q[IDX_LSB +: IDX_W];
      lookup_tag = mem_addr_q[TAG_MSB -: TAG_W];
    end
  end

  assign hit = rd_valid && (rd_tag == lookup_tag);
  assign ack = mem_ack && mem_req_q;

  cache_line_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_lines (
    .realClock (realClock),
    .reset     (reset),
    .rd_idx    (rd_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_tag    (wr_tag),
    .wr_data   (wr_data)
  );

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    retry_d      = retry_q;
    out_stall    = 1'b0;
    out_data     = '0;
    wr_en        = 1'b0;
    wr_idx       = mem_addr_q[IDX_LSB +: IDX_W];
    wr_tag       = mem_addr_q[TAG_MSB -: TAG_W];
    wr_data      = mem_rdata;

    case (state_q)
      IDLE: begin
        if (write) begin
          out_stall   = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {addressData[ADDR_W-1:IDX_LSB], 2'b00};
          mem_wdata_d = value;
          state_d     = WR_THRU;
        end else if (readData) begin
          if (hit) begin
            out_data = rd_data;
            // The hit that completes a miss is not a real hit.
            if (!retry_q) begin
              hit_count_d = hit_count_q + 32'd1;
            end
            retry_d = 1'b0;
          end else begin
            out_stall    = 1'b1;
            mem_req_d    = 1'b1;
            mem_we_d     = 1'b0;
            mem_addr_d   = {addressData[ADDR_W-1:IDX_LSB], 2'b00};
            miss_count_d = miss_count_q + 32'd1;
            state_d      = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        out_stall = 1'b1;
        if (ack) begin
          wr_en     = 1'b1;
          wr_data   = mem_rdata;
          retry_d   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      WR_THRU: begin
        out_stall = 1'b1;
        if (ack) begin
          // No write-allocate: only refresh a line that already holds this word.
          wr_en     = hit;
          wr_data   = mem_wdata_q;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    stall_count_d = out_stall ? stall_count_q + 32'd1 : stall_count_q;
  end

  always_ff @(posedge realClock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
      stall_count_q <= '0;
      retry_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
      stall_count_q <= stall_count_d;
      retry_q       <= retry_d;
    end
  end

  // Outputs are forced quiet while reset is held, even if requests are present.
  assign outStall    = out_stall && !reset;
  assign outData     = reset ? '0 : out_data;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;
  assign stall_count = stall_count_q;

endmodule
